// File: rtl/multi_port_stream_drainer_if.sv
// Handshake bundle for multi_port_stream_drainer: wide lane input side,
// single-lane output side and flush. slave = drainer, master = its peers.
interface multi_port_stream_drainer_if #(
    parameter int InWidth   = 2,
    parameter int DataWidth = 32
);
    logic [InWidth-1:0]                in_vld_i;
    logic [InWidth-1:0][DataWidth-1:0] in_payload_i;
    logic [InWidth-1:0]                in_rdy_o;
    logic                              out_vld_o;
    logic [DataWidth-1:0]              out_payload_o;
    logic                              out_last_o;
    logic                              out_rdy_i;
    logic                              flush_i;

    modport slave (
        input  in_vld_i, in_payload_i, out_rdy_i, flush_i,
        output in_rdy_o, out_vld_o, out_payload_o, out_last_o
    );

    modport master (
        output in_vld_i, in_payload_i, out_rdy_i, flush_i,
        input  in_rdy_o, out_vld_o, out_payload_o, out_last_o
    );
endinterface

// File: rtl/multi_port_stream_drainer.sv
// Captures a contiguous prefix of valid input lanes and replays it one
// entry per cycle. Ports: clk, rstn (async low), bus (slave modport).
module multi_port_stream_drainer #(
    parameter int InWidth   = 2,
    parameter int DataWidth = 32
) (
    input  logic                           clk,
    input  logic                           rstn,
    multi_port_stream_drainer_if.slave     bus
);
    localparam int CW = $clog2(InWidth + 1);
    localparam int IW = (InWidth > 1) ? $clog2(InWidth) : 1;

    logic [DataWidth-1:0] buf_q [InWidth];
    logic [CW-1:0]        cnt_q, cnt_d, k;
    logic [IW-1:0]        rd_idx_q, rd_idx_d;
    logic [InWidth-1:0]   fire;
    logic                 out_vld, last, out_fire, load_ok, run;

    assign out_vld  = (cnt_q != '0);
    assign last     = out_vld && (CW'(rd_idx_q) == cnt_q - CW'(1));
    assign out_fire = out_vld && bus.out_rdy_i;
    // rstn gating keeps ready low while the block is held in reset
    assign load_ok  = rstn && !bus.flush_i && (!out_vld || (out_fire && last));

    assign bus.out_vld_o  = out_vld;
    assign bus.out_last_o = last;

    always_comb begin
        bus.out_payload_o = buf_q[0];
        for (int i = 0; i < InWidth; i++) begin
            if (IW'(i) == rd_idx_q) bus.out_payload_o = buf_q[i];
        end
    end

    // Ready only over the unbroken run of valid lanes starting at lane 0
    always_comb begin
        run  = load_ok;
        fire = '0;
        k    = '0;
        for (int i = 0; i < InWidth; i++) begin
            run     = run & bus.in_vld_i[i];
            fire[i] = run;
            if (run) k = CW'(i + 1);
        end
    end

    assign bus.in_rdy_o = fire;

    // A load in the same cycle as draining the last entry takes priority
    always_comb begin
        cnt_d    = cnt_q;
        rd_idx_d = rd_idx_q;
        if (bus.flush_i) begin
            cnt_d    = '0;
            rd_idx_d = '0;
        end else if (k != '0) begin
            cnt_d    = k;
            rd_idx_d = '0;
        end else if (out_fire) begin
            if (last) begin
                cnt_d    = '0;
                rd_idx_d = '0;
            end else begin
                rd_idx_d = rd_idx_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            rd_idx_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < InWidth; i++) begin
            if (fire[i]) buf_q[i] <= bus.in_payload_i[i];
        end
    end
endmodule

// File: tb/tb_multi_port_stream_drainer.sv
// Directed bench for multi_port_stream_drainer (InWidth=2, DataWidth=32).
// Ports: none; drives the interface master side and checks the slave side.
module tb_multi_port_stream_drainer;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    multi_port_stream_drainer_if #(.InWidth(2), .DataWidth(32)) bus ();

    multi_port_stream_drainer #(.InWidth(2), .DataWidth(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_in(input logic [1:0] v, input logic [31:0] d1,
                          input logic [31:0] d0);
        bus.in_vld_i        = v;
        bus.in_payload_i[1] = d1;
        bus.in_payload_i[0] = d0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.out_rdy_i = 1'b1;
        bus.flush_i = 1'b0;
        set_in(2'b11, 32'h0, 32'h0);
        step();
        step();
        settle();
        total++;
        if (bus.out_vld_o !== 1'b0) begin
            $display("FAIL rst_vld got=%b want=0", bus.out_vld_o); bad++;
        end
        total++;
        if (bus.in_rdy_o !== 2'b00) begin
            $display("FAIL rst_rdy got=%b want=00", bus.in_rdy_o); bad++;
        end
        set_in(2'b00, 32'h0, 32'h0);
        rstn = 1'b1;
        settle();
        set_in(2'b11, 32'h0, 32'h0);
        settle();
        total++;
        if (bus.in_rdy_o !== 2'b11) begin
            $display("FAIL rel_rdy got=%b want=11", bus.in_rdy_o); bad++;
        end
        total++;
        if (bus.out_vld_o !== 1'b0) begin
            $display("FAIL rel_vld got=%b want=0", bus.out_vld_o); bad++;
        end
        set_in(2'b00, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_group();
        bus.out_rdy_i = 1'b1;
        set_in(2'b11, 32'h22, 32'h11);
        settle();
        total++;
        if (bus.in_rdy_o !== 2'b11) begin
            $display("FAIL grp_rdy got=%b want=11", bus.in_rdy_o); bad++;
        end
        step();
        set_in(2'b00, 32'h0, 32'h0);
        settle();
        total++;
        if (bus.out_vld_o !== 1'b1 || bus.out_payload_o !== 32'h11 ||
            bus.out_last_o !== 1'b0) begin
            $display("FAIL grp_n1 got=%b/%h/%b want=1/11/0", bus.out_vld_o,
                     bus.out_payload_o, bus.out_last_o); bad++;
        end
        step();
        set_in(2'b01, 32'h0, 32'h55);
        settle();
        total++;
        if (bus.out_payload_o !== 32'h22 || bus.out_last_o !== 1'b1) begin
            $display("FAIL grp_n2 got=%h/%b want=22/1", bus.out_payload_o,
                     bus.out_last_o); bad++;
        end
        total++;
        if (bus.in_rdy_o !== 2'b01) begin
            $display("FAIL grp_n2rdy got=%b want=01", bus.in_rdy_o); bad++;
        end
        step();
        set_in(2'b00, 32'h0, 32'h0);
        settle();
        total++;
        if (bus.out_payload_o !== 32'h55 || bus.out_last_o !== 1'b1) begin
            $display("FAIL grp_n3 got=%h/%b want=55/1", bus.out_payload_o,
                     bus.out_last_o); bad++;
        end
        step();
        total++;
        if (bus.out_vld_o !== 1'b0) begin
            $display("FAIL grp_empty got=%b want=0", bus.out_vld_o); bad++;
        end
    endtask

    task automatic test_prefix();
        bus.out_rdy_i = 1'b1;
        set_in(2'b10, 32'h77, 32'h0);
        settle();
        total++;
        if (bus.in_rdy_o !== 2'b00) begin
            $display("FAIL pfx_gap got=%b want=00", bus.in_rdy_o); bad++;
        end
        step();
        set_in(2'b00, 32'h0, 32'h0);
        settle();
        total++;
        if (bus.out_vld_o !== 1'b0) begin
            $display("FAIL pfx_noload got=%b want=0", bus.out_vld_o); bad++;
        end
        set_in(2'b01, 32'h0, 32'h66);
        settle();
        total++;
        if (bus.in_rdy_o !== 2'b01) begin
            $display("FAIL pfx_one got=%b want=01", bus.in_rdy_o); bad++;
        end
        step();
        set_in(2'b00, 32'h0, 32'h0);
        settle();
        total++;
        if (bus.out_vld_o !== 1'b1 || bus.out_payload_o !== 32'h66 ||
            bus.out_last_o !== 1'b1) begin
            $display("FAIL pfx_out got=%b/%h/%b want=1/66/1", bus.out_vld_o,
                     bus.out_payload_o, bus.out_last_o); bad++;
        end
        step();
        total++;
        if (bus.out_vld_o !== 1'b0) begin
            $display("FAIL pfx_empty got=%b want=0", bus.out_vld_o); bad++;
        end
    endtask

    task automatic test_backpressure();
        bus.out_rdy_i = 1'b0;
        set_in(2'b11, 32'hB2, 32'hA1);
        step();
        for (int c = 0; c < 5; c++) begin
            set_in(2'b11, 32'hEE00 + c, 32'hDD00 + c);
            settle();
            total++;
            if (bus.out_vld_o !== 1'b1 || bus.out_payload_o !== 32'hA1 ||
                bus.out_last_o !== 1'b0 || bus.in_rdy_o !== 2'b00) begin
                $display("FAIL bp_hold c=%0d got=%b/%h/%b/%b want=1/a1/0/00",
                         c, bus.out_vld_o, bus.out_payload_o,
                         bus.out_last_o, bus.in_rdy_o); bad++;
            end
            step();
        end
        set_in(2'b00, 32'h0, 32'h0);
        bus.out_rdy_i = 1'b1;
        settle();
        total++;
        if (bus.out_payload_o !== 32'hA1) begin
            $display("FAIL bp_first got=%h want=a1", bus.out_payload_o); bad++;
        end
        step();
        total++;
        if (bus.out_payload_o !== 32'hB2 || bus.out_last_o !== 1'b1) begin
            $display("FAIL bp_second got=%h/%b want=b2/1", bus.out_payload_o,
                     bus.out_last_o); bad++;
        end
        step();
        total++;
        if (bus.out_vld_o !== 1'b0) begin
            $display("FAIL bp_empty got=%b want=0", bus.out_vld_o); bad++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] nd;
        logic [31:0] exp;
        logic [1:0]  exp_rdy;
        nd  = 32'd0;
        exp = 32'd0;
        bus.out_rdy_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            set_in(2'b11, nd + 32'd1, nd);
            settle();
            if (c > 0) begin
                total++;
                if (bus.out_vld_o !== 1'b1 || bus.out_payload_o !== exp) begin
                    $display("FAIL b2b_out c=%0d got=%b/%0d want=1/%0d", c,
                             bus.out_vld_o, bus.out_payload_o, exp); bad++;
                end
                exp = exp + 32'd1;
            end
            exp_rdy = (c % 2 == 0) ? 2'b11 : 2'b00;
            total++;
            if (bus.in_rdy_o !== exp_rdy) begin
                $display("FAIL b2b_rdy c=%0d got=%b want=%b", c,
                         bus.in_rdy_o, exp_rdy); bad++;
            end
            if (c % 2 == 0) nd = nd + 32'd2;
            step();
        end
        set_in(2'b00, 32'h0, 32'h0);
        settle();
        total++;
        if (bus.out_payload_o !== exp || bus.out_last_o !== 1'b1) begin
            $display("FAIL b2b_tail got=%0d/%b want=%0d/1",
                     bus.out_payload_o, bus.out_last_o, exp); bad++;
        end
        step();
        total++;
        if (bus.out_vld_o !== 1'b0) begin
            $display("FAIL b2b_empty got=%b want=0", bus.out_vld_o); bad++;
        end
    endtask

    task automatic test_flush();
        bus.out_rdy_i = 1'b1;
        set_in(2'b11, 32'hF2, 32'hF1);
        step();
        set_in(2'b00, 32'h0, 32'h0);
        settle();
        total++;
        if (bus.out_payload_o !== 32'hF1) begin
            $display("FAIL fl_first got=%h want=f1", bus.out_payload_o); bad++;
        end
        step();
        bus.flush_i = 1'b1;
        set_in(2'b11, 32'h99, 32'h98);
        settle();
        total++;
        if (bus.in_rdy_o !== 2'b00 || bus.out_payload_o !== 32'hF2) begin
            $display("FAIL fl_cycle got=%b/%h want=00/f2", bus.in_rdy_o,
                     bus.out_payload_o); bad++;
        end
        step();
        bus.flush_i = 1'b0;
        set_in(2'b00, 32'h0, 32'h0);
        settle();
        total++;
        if (bus.out_vld_o !== 1'b0) begin
            $display("FAIL fl_after got=%b want=0", bus.out_vld_o); bad++;
        end
        set_in(2'b11, 32'h0D, 32'h0C);
        settle();
        total++;
        if (bus.in_rdy_o !== 2'b11) begin
            $display("FAIL fl_rdy got=%b want=11", bus.in_rdy_o); bad++;
        end
        step();
        set_in(2'b00, 32'h0, 32'h0);
        settle();
        total++;
        if (bus.out_payload_o !== 32'h0C || bus.out_last_o !== 1'b0) begin
            $display("FAIL fl_reload got=%h/%b want=0c/0",
                     bus.out_payload_o, bus.out_last_o); bad++;
        end
        step();
        total++;
        if (bus.out_payload_o !== 32'h0D || bus.out_last_o !== 1'b1) begin
            $display("FAIL fl_reload2 got=%h/%b want=0d/1",
                     bus.out_payload_o, bus.out_last_o); bad++;
        end
        step();
    endtask

    initial begin
        test_reset();
        test_group();
        test_prefix();
        test_backpressure();
        test_back_to_back();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
